sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
Arbitrates two sram-like masters, the i-cache miss port (m0) and the d-cache miss/writeback port (m1), onto one sram-like slave port that feeds the AXI bridge.
Grants address handshakes and records each accepted transaction's owner in an in-order tracking FIFO. Routes each slave data_ok/rdata back to the owning master.
Sits between i_cache/d_cache and the AXI interface in the CPU top.

Parameters:
OUTST_DEPTH, 2, maximum accepted-but-unanswered transactions; power of 2, ≥1
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
m0_req  in  1  inst master request
m0_wr  in  1  inst master write
m0_size  in  2  0=byte, 1=half, 2=word
m0_addr  in  AW  inst master address
m0_wdata  in  DW  inst master write data
m0_rdata  out  DW  read data to inst master
m0_addr_ok  out  1  inst address accepted
m0_data_ok  out  1  inst response valid
m1_req, m1_wr, m1_size, m1_addr, m1_wdata, m1_rdata, m1_addr_ok, m1_data_ok  same directions/widths as m0_*, for the data master
s_req  out  1  slave request
s_wr  out  1  slave write
s_size  out  2  slave size
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_rdata  in  DW  slave read data
s_addr_ok  in  1  slave address accept
s_data_ok  in  1  slave response (in order of acceptance)
outst_cnt  out  $clog2(OUTST_DEPTH)+1  live outstanding count
resp_err  out  1  sticky: s_data_ok received with nothing outstanding

Behaviour:
- Reset (resetn=0 at posedge): grant FSM→IDLE, FIFO pointers/count→0, resp_err→0. While the FIFO is empty and the FSM is IDLE, s_req, all addr_ok and all data_ok are 0.
- Grant FSM states: IDLE, LOCK_M0, LOCK_M1.
  - IDLE: winner chosen combinationally from the current m0_req/m1_req. s_* is muxed from the winner in the same cycle (zero-cycle latency).
  - If the winner's s_req is not answered by s_addr_ok that cycle, go to LOCK_<winner>. The grant is held until s_addr_ok, so the slave sees stable req/addr.
  - LOCK_x: s_* driven from master x only. On s_req & s_addr_ok, return to IDLE.
- Default policy: fixed priority, m1 (data) over m0 (inst).
- Full: when outst_cnt==OUTST_DEPTH, s_req is forced 0 and the FSM holds its state; no grant is issued.
- mX_addr_ok = s_addr_ok & s_req & (granted==X).
- Push: on s_req & s_addr_ok, the owner id (1 bit) is written at the FIFO tail.
- Pop: on s_data_ok with count>0, the head is popped. m<head>_data_ok=1 for exactly that cycle; the other master's data_ok=0.
- m0_rdata = m1_rdata = s_rdata unconditionally. Masters qualify rdata with their own data_ok.
- Push and pop in the same cycle: count unchanged, both pointers advance. A push on the same cycle a full FIFO pops is not allowed, because s_req is gated on the registered full flag.
- s_data_ok with count==0: ignored (no data_ok to either master), and resp_err is set and stays set until reset.
- Pointers wrap modulo OUTST_DEPTH.
- A master dropping req while LOCKed is a protocol violation. The FSM stays LOCKed; an SVA assertion flags it in simulation.
- Reset mid-transaction discards all outstanding entries. A stale late s_data_ok after reset sets resp_err.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: IDLE arbitration is round-robin. A last_grant register (reset value m0) records the master last granted; on simultaneous requests the other master wins. last_grant updates on each s_addr_ok.
- Undefined: fixed m1-over-m0 priority as above, and no last_grant register exists.

Decomposition:
- Shared package cpu_bus_pkg: sram-like size constants (SZ_BYTE/SZ_HALF/SZ_WORD), owner id constants OWN_INST=0 and OWN_DATA=1, grant FSM state enum.
- One sub-module, arb_owner_fifo: a parameterised 1-bit-wide sync FIFO with push, pop, head, count, full, empty.

Test Plan:
1. Single read: m0_req, addr 0xBFC00000, s_addr_ok the same cycle, s_data_ok 3 cycles later with rdata 0x3C1D0001 → m0_addr_ok for 1 cycle, m0_data_ok for 1 cycle with m0_rdata=0x3C1D0001, m1_data_ok=0 throughout.
2. Simultaneous m0 (0x1000) and m1 (0x2000), fixed priority → s_addr=0x2000 first, then 0x1000. data_ok is routed to m1 first, then to m0.
3. s_addr_ok held low for 4 cycles while m1 requests mid-lock on m0 → s_addr stays at m0's address for all 4 cycles, and m1 is granted only after m0's addr_ok.
4. OUTST_DEPTH=2: three back-to-back accepts attempted without data_ok → the third s_req stays 0 until the first s_data_ok. outst_cnt sequence is 1, 2, 2, then 1 after the pop.
5. s_data_ok pulse with nothing outstanding → no master data_ok, resp_err=1 and held. resetn low for 1 cycle → resp_err=0, outst_cnt=0.
6. ARB_ROUND_ROBIN_EN defined, both masters requesting continuously with immediate s_addr_ok → grants alternate m1, m0, m1, m0 (last_grant reset value m0).

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared sram-like bus definitions: transfer size codes, owner ids and the
// grant FSM state type used by the two-master arbiter.
package cpu_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK_M0 = 2'd1,
        ST_LOCK_M1 = 2'd2
    } arb_state_e;

    // Lock state that holds the grant for the given owner.
    function automatic arb_state_e lock_state(input logic owner);
        return (owner == OWN_DATA) ? ST_LOCK_M1 : ST_LOCK_M0;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Sram-like bus bundle. The master modport drives the request side and
// receives the handshakes; the slave modport is the opposite view.
interface sram_like_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          addr_ok;
    logic          data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/arb_owner_fifo.sv
// In-order owner tracking FIFO: one bit per accepted transaction, popped when
// the matching response returns. Pushes when full and pops when empty are
// ignored so the count can never wrap.
module arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic                       din_i,
    input  logic                       pop_i,
    output logic                       head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointer advance with explicit wrap so non-power-of-two depths stay legal.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
    endfunction

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Next pointer and occupancy values from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Owner storage, written at the tail on each accepted push.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 1'b0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sram_like_arbiter_chk.sv
// Protocol checker: a master that has been locked onto the slave must keep
// its request up until the address is accepted.
module sram_like_arbiter_chk
    import cpu_bus_pkg::*;
(
    input logic       clk,
    input logic       resetn,
    input arb_state_e state_i,
    input logic       m0_req_i,
    input logic       m1_req_i
);
    a_m0_hold_req: assert property (@(posedge clk) disable iff (!resetn)
        (state_i == ST_LOCK_M0) |-> m0_req_i);

    a_m1_hold_req: assert property (@(posedge clk) disable iff (!resetn)
        (state_i == ST_LOCK_M1) |-> m1_req_i);
endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter (m0 = i-cache, m1 = d-cache) onto one slave.
// The winner is muxed onto the slave in the same cycle; an unanswered request
// locks the grant until s_addr_ok. Accepted owners are queued in order so
// each response is routed back to the master that issued it.
// Build option ARB_ROUND_ROBIN_EN: alternate on simultaneous requests instead
// of the default fixed m1-over-m0 priority.
module sram_like_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int OUTST_DEPTH = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    sram_like_arbiter_if.slave             m0,
    sram_like_arbiter_if.slave             m1,
    sram_like_arbiter_if.master            s,
    output logic [$clog2(OUTST_DEPTH):0]   outst_cnt,
    output logic                           resp_err
);
    arb_state_e    state_q, state_d;
    logic          owner_s;
    logic          sel_req_s;
    logic          s_req_s;
    logic          accept_s;
    logic          pop_s;
    logic          head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          resp_err_q;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic          last_grant_q;
`endif

    // Grant selection and next state for the IDLE/LOCK grant FSM.
    always_comb begin
        owner_s   = OWN_INST;
        sel_req_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m0.req && m1.req) begin
                    owner_s = ~last_grant_q;
                end else if (m1.req) begin
                    owner_s = OWN_DATA;
                end else begin
                    owner_s = OWN_INST;
                end
`else
                if (m1.req) begin
                    owner_s = OWN_DATA;
                end else begin
                    owner_s = OWN_INST;
                end
`endif
                sel_req_s = m0.req | m1.req;
            end
            ST_LOCK_M0: begin
                owner_s   = OWN_INST;
                sel_req_s = m0.req;
            end
            ST_LOCK_M1: begin
                owner_s   = OWN_DATA;
                sel_req_s = m1.req;
            end
            default: begin
                owner_s   = OWN_INST;
                sel_req_s = 1'b0;
            end
        endcase

        // A full tracking FIFO blocks the request, which also freezes the FSM.
        s_req_s  = sel_req_s & ~fifo_full_s;
        accept_s = s_req_s & s.addr_ok;

        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = (s_req_s && !s.addr_ok) ? lock_state(owner_s) : ST_IDLE;
            ST_LOCK_M0: state_d = accept_s ? ST_IDLE : ST_LOCK_M0;
            ST_LOCK_M1: state_d = accept_s ? ST_IDLE : ST_LOCK_M1;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the most recently accepted master for round-robin tie breaks.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_q <= OWN_INST;
        end else if (accept_s) begin
            last_grant_q <= owner_s;
        end
    end
`endif

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_err_q <= 1'b0;
        end else if (s.data_ok && fifo_empty_s) begin
            resp_err_q <= 1'b1;
        end
    end

    arb_owner_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (accept_s),
        .din_i   (owner_s),
        .pop_i   (s.data_ok),
        .head_o  (head_s),
        .count_o (outst_cnt),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    sram_like_arbiter_chk u_chk (
        .clk      (clk),
        .resetn   (resetn),
        .state_i  (state_q),
        .m0_req_i (m0.req),
        .m1_req_i (m1.req)
    );

    assign sel_addr_s  = (owner_s == OWN_DATA) ? m1.addr  : m0.addr;
    assign sel_wdata_s = (owner_s == OWN_DATA) ? m1.wdata : m0.wdata;

    assign s.req   = s_req_s;
    assign s.wr    = (owner_s == OWN_DATA) ? m1.wr   : m0.wr;
    assign s.size  = (owner_s == OWN_DATA) ? m1.size : m0.size;
    assign s.addr  = sel_addr_s;
    assign s.wdata = sel_wdata_s;

    assign m0.addr_ok = accept_s & (owner_s == OWN_INST);
    assign m1.addr_ok = accept_s & (owner_s == OWN_DATA);

    assign pop_s      = s.data_ok & ~fifo_empty_s;
    assign m0.data_ok = pop_s & (head_s == OWN_INST);
    assign m1.data_ok = pop_s & (head_s == OWN_DATA);

    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign resp_err = resp_err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave checked every cycle against a queue-based
// model of grants, outstanding owners and the sticky response error.
module tb_sram_like_arbiter;
    import cpu_bus_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [CW-1:0] outst_cnt;
    logic          resp_err;

    sram_like_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    sram_like_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    sram_like_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    sram_like_arbiter #(.OUTST_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .outst_cnt (outst_cnt),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state (written only by the compare process).
    int q_own[$];
    bit err_m    = 1'b0;
    int lock_m   = -1;
    bit last_m   = 1'b0;
    bit model_on = 1'b0;
    bit aok_m [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: checks every cycle once reset has been seen.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                q_own.delete();
                err_m    = 1'b0;
                lock_m   = -1;
                last_m   = 1'b0;
                model_on = 1'b1;
                aok_m[0] = 1'b0;
                aok_m[1] = 1'b0;
            end else if (model_on) begin
                bit r [2];
                bit dok [2];
                int own;
                bit exp_req;
                bit acc;
                r[0] = m0_if.req;
                r[1] = m1_if.req;
                own  = -1;
                if (lock_m >= 0) begin
                    own = lock_m;
                end else if (r[0] || r[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (r[0] && r[1]) own = last_m ? 0 : 1;
                    else              own = r[1] ? 1 : 0;
`else
                    own = r[1] ? 1 : 0;
`endif
                end
                exp_req = (q_own.size() < DEPTH) && (own >= 0) && r[own];
                acc     = exp_req && s_if.addr_ok;
                dok[0]  = 1'b0;
                dok[1]  = 1'b0;
                if (s_if.data_ok && q_own.size() > 0) dok[q_own[0]] = 1'b1;

                chk("s_req", 64'(s_if.req), 64'(exp_req));
                if (exp_req) begin
                    chk("s_addr",  64'(s_if.addr),  64'(own == 1 ? m1_if.addr  : m0_if.addr));
                    chk("s_wr",    64'(s_if.wr),    64'(own == 1 ? m1_if.wr    : m0_if.wr));
                    chk("s_size",  64'(s_if.size),  64'(own == 1 ? m1_if.size  : m0_if.size));
                    chk("s_wdata", 64'(s_if.wdata), 64'(own == 1 ? m1_if.wdata : m0_if.wdata));
                end
                chk("m0_addr_ok", 64'(m0_if.addr_ok), 64'(acc && own == 0));
                chk("m1_addr_ok", 64'(m1_if.addr_ok), 64'(acc && own == 1));
                chk("m0_data_ok", 64'(m0_if.data_ok), 64'(dok[0]));
                chk("m1_data_ok", 64'(m1_if.data_ok), 64'(dok[1]));
                chk("m0_rdata",   64'(m0_if.rdata),   64'(s_if.rdata));
                chk("m1_rdata",   64'(m1_if.rdata),   64'(s_if.rdata));
                chk("outst_cnt",  64'(outst_cnt),     64'(q_own.size()));
                chk("resp_err",   64'(resp_err),      64'(err_m));

                if (s_if.data_ok) begin
                    if (q_own.size() > 0) void'(q_own.pop_front());
                    else                  err_m = 1'b1;
                end
                if (acc) begin
                    q_own.push_back(own);
                    last_m = own[0];
                    lock_m = -1;
                end else if (exp_req) begin
                    lock_m = own;
                end
                aok_m[0] = acc && own == 0;
                aok_m[1] = acc && own == 1;
            end
        end
    end

    // Randomized master state.
    bit          mreq [2];
    bit          mwr  [2];
    logic [1:0]  msz  [2];
    logic [31:0] madr [2];
    logic [31:0] mwd  [2];

    // Stimulus and directed literal checks.
    initial begin
        m0_if.req = 1'b0; m0_if.wr = 1'b0; m0_if.size = SZ_WORD; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.wr = 1'b0; m1_if.size = SZ_WORD; m1_if.addr = '0; m1_if.wdata = '0;
        s_if.addr_ok = 1'b0; s_if.data_ok = 1'b0; s_if.rdata = '0;
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_cnt",  64'(outst_cnt), 64'd0);
        chk("rst_err",  64'(resp_err),  64'd0);
        chk("rst_sreq", 64'(s_if.req),  64'd0);
        tick();

        // Single read from m0, response three cycles after acceptance.
        m0_if.req = 1'b1; m0_if.addr = 32'hBFC0_0000; s_if.addr_ok = 1'b1;
        @(negedge clk);
        chk("t1_aok",   64'(m0_if.addr_ok), 64'd1);
        chk("t1_saddr", 64'(s_if.addr),     64'hBFC0_0000);
        tick();
        m0_if.req = 1'b0; s_if.addr_ok = 1'b0;
        tick();
        tick();
        s_if.data_ok = 1'b1; s_if.rdata = 32'h3C1D_0001;
        @(negedge clk);
        chk("t1_dok",   64'(m0_if.data_ok), 64'd1);
        chk("t1_rdata", 64'(m0_if.rdata),   64'h3C1D_0001);
        chk("t1_m1dok", 64'(m1_if.data_ok), 64'd0);
        tick();
        s_if.data_ok = 1'b0;
        @(negedge clk);
        chk("t1_cnt", 64'(outst_cnt), 64'd0);
        tick();

        // Simultaneous requests: m1 first, responses routed in order.
        m0_if.req = 1'b1; m0_if.addr = 32'h1000;
        m1_if.req = 1'b1; m1_if.addr = 32'h2000;
        s_if.addr_ok = 1'b1;
        @(negedge clk);
        chk("t2_first", 64'(s_if.addr),     64'h2000);
        chk("t2_m1aok", 64'(m1_if.addr_ok), 64'd1);
        tick();
        m1_if.req = 1'b0;
        @(negedge clk);
        chk("t2_second", 64'(s_if.addr),     64'h1000);
        chk("t2_m0aok",  64'(m0_if.addr_ok), 64'd1);
        tick();
        m0_if.req = 1'b0; s_if.addr_ok = 1'b0; s_if.data_ok = 1'b1;
        @(negedge clk);
        chk("t2_d1_m1", 64'(m1_if.data_ok), 64'd1);
        chk("t2_d1_m0", 64'(m0_if.data_ok), 64'd0);
        tick();
        @(negedge clk);
        chk("t2_d2_m0", 64'(m0_if.data_ok), 64'd1);
        tick();
        s_if.data_ok = 1'b0;

        // Lock on m0 while the slave stalls; m1 requests mid-lock.
        m0_if.req = 1'b1; m0_if.addr = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold",   64'(s_if.addr),     64'h3000);
            chk("t3_m1wait", 64'(m1_if.addr_ok), 64'd0);
            tick();
            if (i == 0) begin
                m1_if.req = 1'b1; m1_if.addr = 32'h4000;
            end
        end
        s_if.addr_ok = 1'b1;
        @(negedge clk);
        chk("t3_m0aok", 64'(m0_if.addr_ok), 64'd1);
        chk("t3_addr0", 64'(s_if.addr),     64'h3000);
        tick();
        m0_if.req = 1'b0;
        @(negedge clk);
        chk("t3_m1aok", 64'(m1_if.addr_ok), 64'd1);
        chk("t3_addr1", 64'(s_if.addr),     64'h4000);
        tick();
        m1_if.req = 1'b0; s_if.addr_ok = 1'b0; s_if.data_ok = 1'b1;
        tick();
        tick();
        s_if.data_ok = 1'b0;

        // Full tracking FIFO blocks the third request until a pop.
        m0_if.req = 1'b1; m0_if.addr = 32'h5000; s_if.addr_ok = 1'b1;
        @(negedge clk);
        chk("t4_sreq0", 64'(s_if.req), 64'd1);
        tick();
        @(negedge clk);
        chk("t4_cnt1",  64'(outst_cnt), 64'd1);
        chk("t4_sreq1", 64'(s_if.req),  64'd1);
        tick();
        @(negedge clk);
        chk("t4_cnt2",  64'(outst_cnt), 64'd2);
        chk("t4_sreq2", 64'(s_if.req),  64'd0);
        tick();
        s_if.data_ok = 1'b1;
        @(negedge clk);
        chk("t4_cnt3",  64'(outst_cnt), 64'd2);
        chk("t4_sreq3", 64'(s_if.req),  64'd0);
        tick();
        s_if.data_ok = 1'b0;
        @(negedge clk);
        chk("t4_cnt4",  64'(outst_cnt), 64'd1);
        chk("t4_sreq4", 64'(s_if.req),  64'd1);
        tick();
        m0_if.req = 1'b0; s_if.addr_ok = 1'b0; s_if.data_ok = 1'b1;
        tick();
        tick();
        s_if.data_ok = 1'b0;
        @(negedge clk);
        chk("t4_drain", 64'(outst_cnt), 64'd0);
        tick();

        // Response with nothing outstanding, then reset clears the error.
        s_if.data_ok = 1'b1;
        @(negedge clk);
        chk("t5_m0dok", 64'(m0_if.data_ok), 64'd0);
        chk("t5_m1dok", 64'(m1_if.data_ok), 64'd0);
        tick();
        s_if.data_ok = 1'b0;
        @(negedge clk);
        chk("t5_err1", 64'(resp_err), 64'd1);
        tick();
        @(negedge clk);
        chk("t5_err2", 64'(resp_err), 64'd1);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("t5_err_rst", 64'(resp_err),  64'd0);
        chk("t5_cnt_rst", 64'(outst_cnt), 64'd0);
        tick();

        // Randomized traffic; masters hold req until their addr_ok.
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0; mwr[m] = 1'b0; msz[m] = SZ_WORD; madr[m] = '0; mwd[m] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (mreq[m] && aok_m[m]) mreq[m] = 1'b0;
                if (!mreq[m] && ($urandom_range(0, 1) == 1)) begin
                    mreq[m] = 1'b1;
                    mwr[m]  = 1'($urandom_range(0, 1));
                    msz[m]  = 2'($urandom_range(0, 2));
                    madr[m] = $urandom;
                    mwd[m]  = $urandom;
                end
            end
            m0_if.req = mreq[0]; m0_if.wr = mwr[0]; m0_if.size = msz[0];
            m0_if.addr = madr[0]; m0_if.wdata = mwd[0];
            m1_if.req = mreq[1]; m1_if.wr = mwr[1]; m1_if.size = msz[1];
            m1_if.addr = madr[1]; m1_if.wdata = mwd[1];
            s_if.addr_ok = ($urandom_range(0, 3) != 0);
            s_if.data_ok = (q_own.size() > 0) && ($urandom_range(0, 1) == 1);
            s_if.rdata   = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
